// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding, parameter-word tags and default sizes for conv_sched.
package conv_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARAM = 2'd1,
        ST_FEED  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] TAG_WEIGHT   = 2'd0;
    localparam logic [1:0] TAG_BIAS     = 2'd1;
    localparam int         PIX_W_DEF    = 24;
    localparam int         LANES_DEF    = 7;
    // nine 8-bit weights per frame, packed three to a word
    localparam logic [3:0] WEIGHT_BYTES = 4'd9;

    function automatic logic [25:0] mk_param(input logic [1:0] tag, input logic [23:0] data);
        return {tag, data};
    endfunction
endpackage

// File: rtl/param_packer.sv
// param_packer: gathers three bytes into one 24-bit word, first byte in the msbs.
// The word and its strobe are combinational on the third byte so the caller
// can register them together with its own tag.
module param_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic [23:0] word,
    output logic        word_valid
);
    logic [1:0]  pos;
    logic [15:0] acc;

    assign word       = {acc, byte_data};
    assign word_valid = byte_valid && (pos == 2'd2);

    // shift in accepted bytes and track position within the current word
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pos <= 2'd0;
            acc <= 16'd0;
        end else if (byte_valid) begin
            pos <= (pos == 2'd2) ? 2'd0 : pos + 2'd1;
            acc <= {acc[7:0], byte_data};
        end
    end
endmodule

// File: rtl/conv_sched.sv
// conv_sched: per-frame scheduler -- streams 9 weights + bias to the conv
// parameter port, then feeds cfg_beats pixel beats, waits PIPE_LAT cycles, pulses done.
// Optional feature macro: CONV_SCHED_BIAS_EN (bias taken from a 10th param byte;
// otherwise a zero bias word is generated after the third weight word).
module conv_sched
    import conv_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int PIPE_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [11:0]            cfg_beats,
    input  logic [7:0]             s_param_data,
    input  logic                   s_param_valid,
    output logic                   s_param_ready,
    input  logic [LANES*PIX_W-1:0] s_pix_data,
    input  logic                   s_pix_valid,
    output logic                   s_pix_ready,
    output logic [25:0]            o_param,
    output logic                   o_param_valid,
    output logic [LANES*PIX_W-1:0] o_pe_data,
    output logic                   o_pe_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int FW = $clog2(PIPE_LAT + 1);
`ifdef CONV_SCHED_BIAS_EN
    localparam logic [3:0] PARAM_BYTES = WEIGHT_BYTES + 4'd1;
`else
    localparam logic [3:0] PARAM_BYTES = WEIGHT_BYTES;
`endif

    state_t        state, state_nx;
    logic [11:0]   beats_lat, beat_cnt;
    logic [3:0]    byte_cnt;
    logic [FW-1:0] flush_cnt;
    logic          param_fire, pix_fire, pk_in, pk_valid;
    logic          bias_emit, bias_seen, last_beat, flush_end;
    logic [23:0]   pk_word, bias_data;

    assign param_fire = s_param_valid && s_param_ready;
    assign pix_fire   = s_pix_valid && s_pix_ready;
    assign pk_in      = param_fire && (byte_cnt < WEIGHT_BYTES);
    assign last_beat  = ({1'b0, beat_cnt} + 13'd1) == {1'b0, beats_lat};
    assign flush_end  = flush_cnt == FW'(PIPE_LAT - 1);
    // bias word is on o_param this cycle; FEED starts next cycle
    assign bias_seen  = (state == ST_PARAM) && o_param_valid && (o_param[25:24] == TAG_BIAS);
`ifdef CONV_SCHED_BIAS_EN
    assign bias_emit  = param_fire && (byte_cnt == WEIGHT_BYTES);
    assign bias_data  = {16'd0, s_param_data};
`else
    // third weight word is on o_param: follow it with a zero bias
    assign bias_emit  = (state == ST_PARAM) && o_param_valid &&
                        (o_param[25:24] == TAG_WEIGHT) && (byte_cnt == WEIGHT_BYTES);
    assign bias_data  = 24'd0;
`endif

    param_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (abort),
        .byte_data  (s_param_data),
        .byte_valid (pk_in),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // next-state: abort wins everywhere; empty frames skip FEED as the bias goes out
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nx = ST_PARAM;
                ST_PARAM: if (bias_emit && beats_lat == 12'd0) state_nx = ST_FLUSH;
                          else if (bias_seen) state_nx = ST_FEED;
                ST_FEED:  if (pix_fire && last_beat) state_nx = ST_FLUSH;
                ST_FLUSH: if (flush_end) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // state-decoded handshake and status outputs
    always_comb begin
        s_param_ready = (state == ST_PARAM) && (byte_cnt < PARAM_BYTES);
        s_pix_ready   = (state == ST_FEED);
        busy          = (state != ST_IDLE);
    end

    // counters, parameter/pixel output registers and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_lat     <= 12'd0;
            beat_cnt      <= 12'd0;
            byte_cnt      <= 4'd0;
            flush_cnt     <= '0;
            o_param       <= 26'd0;
            o_param_valid <= 1'b0;
            o_pe_data     <= '0;
            o_pe_valid    <= 1'b0;
            done          <= 1'b0;
        end else begin
            o_param_valid <= 1'b0;
            o_pe_valid    <= 1'b0;
            done          <= 1'b0;
            if (abort) begin
                byte_cnt  <= 4'd0;
                beat_cnt  <= 12'd0;
                flush_cnt <= '0;
            end else begin
                if (state == ST_IDLE && start) begin
                    beats_lat <= cfg_beats;
                    byte_cnt  <= 4'd0;
                    beat_cnt  <= 12'd0;
                    flush_cnt <= '0;
                end
                if (param_fire) byte_cnt <= byte_cnt + 4'd1;
                if (pk_valid) begin
                    o_param       <= mk_param(TAG_WEIGHT, pk_word);
                    o_param_valid <= 1'b1;
                end
                if (bias_emit) begin
                    o_param       <= mk_param(TAG_BIAS, bias_data);
                    o_param_valid <= 1'b1;
                end
                if (pix_fire) begin
                    o_pe_data  <= s_pix_data;
                    o_pe_valid <= 1'b1;
                    beat_cnt   <= beat_cnt + 12'd1;
                end
                if (state == ST_FLUSH) begin
                    if (flush_end) begin
                        done      <= 1'b1;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: randomized frames checked against a queue-based frame model.
module tb_conv_sched;
    localparam int PIX_W    = 24;
    localparam int LANES    = 7;
    localparam int PIPE_LAT = 4;
    localparam int DW       = PIX_W * LANES;
`ifdef CONV_SCHED_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif
    localparam int NB_EXP = BIAS_EN ? 10 : 9;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [11:0]   cfg_beats;
    logic [7:0]    s_param_data;
    logic          s_param_valid, s_param_ready;
    logic [DW-1:0] s_pix_data;
    logic          s_pix_valid, s_pix_ready;
    logic [25:0]   o_param;
    logic          o_param_valid;
    logic [DW-1:0] o_pe_data;
    logic          o_pe_valid, busy, done;

    always #5 clk = ~clk;

    conv_sched #(.PIX_W(PIX_W), .LANES(LANES), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_beats(cfg_beats),
        .s_param_data(s_param_data), .s_param_valid(s_param_valid), .s_param_ready(s_param_ready),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
        .o_param(o_param), .o_param_valid(o_param_valid),
        .o_pe_data(o_pe_data), .o_pe_valid(o_pe_valid), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // observed output events, tagged with the cycle they were seen in
    int            cyc = 0;
    logic [25:0]   param_q[$];
    int            param_cyc[$];
    logic [DW-1:0] pe_q[$];
    int            pe_cyc[$];
    int            done_cyc[$];
    int            pix_rdy_cnt = 0;
    int            param_xfer = 0;

    always @(negedge clk) begin
        if (o_param_valid) begin param_q.push_back(o_param); param_cyc.push_back(cyc); end
        if (o_pe_valid) begin pe_q.push_back(o_pe_data); pe_cyc.push_back(cyc); end
        if (done) done_cyc.push_back(cyc);
        if (s_pix_ready) pix_rdy_cnt = pix_rdy_cnt + 1;
        cyc = cyc + 1;
    end

    always @(posedge clk) if (s_param_valid && s_param_ready) param_xfer = param_xfer + 1;

    // frame model: the bytes and beats offered, and what must come out
    logic [7:0]    exp_bytes[10];
    logic [DW-1:0] exp_pix[$];
    int            pb, eb, db, xb, rb;
    bit            timeout, busy_next, abort_busy, abort_ovld;

    function automatic logic [25:0] exp_param(input int i);
        if (i < 3) return {2'd0, exp_bytes[3*i], exp_bytes[3*i+1], exp_bytes[3*i+2]};
        if (BIAS_EN) return {2'd1, 16'd0, exp_bytes[9]};
        return {2'd1, 24'd0};
    endfunction

    function automatic logic [DW-1:0] rand_pix();
        logic [DW-1:0] v = '0;
        repeat (6) v = (v << 32) | DW'($urandom());
        return v;
    endfunction

    task automatic gen_frame(input int beats);
        for (int b = 0; b < 10; b++) exp_bytes[b] = 8'($urandom());
        exp_pix.delete();
        for (int k = 0; k < beats; k++) exp_pix.push_back(rand_pix());
    endtask

    // drives one frame from a negedge; optional stalls, abort points and a start while busy
    task automatic drive_frame(input int beats, input bit stall, input int abort_pix,
                               input int abort_byte, input bit busy_start);
        int bi, pi;
        bit pa, xa, stop, tog;
        pb = param_q.size(); eb = pe_q.size(); db = done_cyc.size();
        xb = param_xfer; rb = pix_rdy_cnt;
        timeout = 0; abort_busy = 1'b1; abort_ovld = 1'b1;
        start = 1'b1; cfg_beats = 12'(beats);
        @(negedge clk);
        start = 1'b0; busy_next = busy;
        bi = 0; pi = 0; stop = 0;
        for (int c = 0; c < 400 && !stop; c++) begin
            if ((abort_byte >= 0 && bi == abort_byte) || (abort_pix >= 0 && pi == abort_pix)) begin
                abort = 1'b1; s_param_valid = 1'b0; s_pix_valid = 1'b0; start = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                abort_busy = busy;
                abort_ovld = o_param_valid | o_pe_valid;
                stop = 1;
            end else begin
                start = busy_start && (c == 2);
                if (start) cfg_beats = 12'd7;
                tog = !stall || (c % 2 == 0);
                s_param_valid = tog && (bi < 10);
                s_param_data  = (bi < 10) ? exp_bytes[bi] : 8'h00;
                s_pix_valid   = tog && (pi < beats);
                s_pix_data    = (pi < beats) ? exp_pix[pi] : '0;
                pa = s_param_valid && s_param_ready;
                xa = s_pix_valid && s_pix_ready;
                @(negedge clk);
                if (pa) bi++;
                if (xa) pi++;
                if (done) stop = 1;
            end
        end
        start = 1'b0; s_param_valid = 1'b0; s_pix_valid = 1'b0;
        if (!stop) timeout = 1;
        repeat (PIPE_LAT + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_beats = 12'd0;
        s_param_data = 8'h00; s_param_valid = 1'b0; s_pix_data = '0; s_pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_param !== 26'd0) begin errors++; $display("FAIL reset_o_param got %h want 0", o_param); end
        checks++; if (o_pe_data !== '0) begin errors++; $display("FAIL reset_o_pe_data got %h want 0", o_pe_data); end
        checks++;
        if ({o_param_valid, o_pe_valid, s_param_ready, s_pix_ready, busy, done} !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {o_param_valid, o_pe_valid, s_param_ready, s_pix_ready, busy, done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int b = 0; b < 10; b++) exp_bytes[b] = 8'(b + 1);
        exp_pix.delete();
        repeat (2) exp_pix.push_back(rand_pix());
        drive_frame(2, 0, -1, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (busy_next !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy_next); end
        checks++; if (param_q.size() - pb != 4) begin errors++; $display("FAIL basic_param_count got %0d want 4", param_q.size() - pb); end
        for (int i = 0; i < 4 && pb + i < param_q.size(); i++) begin
            checks++;
            if (param_q[pb+i] !== exp_param(i)) begin errors++; $display("FAIL basic_param[%0d] got %h want %h", i, param_q[pb+i], exp_param(i)); end
        end
        checks++; if (pe_q.size() - eb != 2) begin errors++; $display("FAIL basic_pe_count got %0d want 2", pe_q.size() - eb); end
        for (int i = 0; i < 2 && eb + i < pe_q.size(); i++) begin
            checks++;
            if (pe_q[eb+i] !== exp_pix[i]) begin errors++; $display("FAIL basic_pe[%0d] got %h want %h", i, pe_q[eb+i], exp_pix[i]); end
        end
        checks++; if (done_cyc.size() - db != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cyc.size() - db); end
        if (done_cyc.size() > db && pe_q.size() > eb) begin
            checks++;
            if (done_cyc[db] != pe_cyc[pe_cyc.size()-1] + PIPE_LAT) begin
                errors++; $display("FAIL basic_done_time got %0d want %0d", done_cyc[db], pe_cyc[pe_cyc.size()-1] + PIPE_LAT);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    endtask

    task automatic test_stall_random();
        for (int r = 0; r < 4; r++) begin
            int beats;
            beats = $urandom_range(1, 12);
            gen_frame(beats);
            for (int s = 0; s < 2; s++) begin
                drive_frame(beats, s[0], -1, -1, 0);
                checks++; if (timeout) begin errors++; $display("FAIL stall%0d_timeout got no done want done", s); end
                checks++; if (param_q.size() - pb != 4) begin errors++; $display("FAIL stall%0d_param_count got %0d want 4", s, param_q.size() - pb); end
                for (int i = 0; i < 4 && pb + i < param_q.size(); i++) begin
                    checks++;
                    if (param_q[pb+i] !== exp_param(i)) begin errors++; $display("FAIL stall%0d_param[%0d] got %h want %h", s, i, param_q[pb+i], exp_param(i)); end
                end
                checks++; if (pe_q.size() - eb != beats) begin errors++; $display("FAIL stall%0d_pe_count got %0d want %0d", s, pe_q.size() - eb, beats); end
                for (int i = 0; i < beats && eb + i < pe_q.size(); i++) begin
                    checks++;
                    if (pe_q[eb+i] !== exp_pix[i]) begin errors++; $display("FAIL stall%0d_pe[%0d] got %h want %h", s, i, pe_q[eb+i], exp_pix[i]); end
                end
                if (done_cyc.size() > db && pe_q.size() > eb) begin
                    checks++;
                    if (done_cyc[db] != pe_cyc[pe_cyc.size()-1] + PIPE_LAT) begin
                        errors++; $display("FAIL stall%0d_done_time got %0d want %0d", s, done_cyc[db], pe_cyc[pe_cyc.size()-1] + PIPE_LAT);
                    end
                end
            end
        end
    endtask

    task automatic test_zero_beats();
        gen_frame(0);
        drive_frame(0, 0, -1, -1, 0);
        checks++; if (timeout) begin errors++; $display("FAIL zero_timeout got no done want done"); end
        checks++; if (pix_rdy_cnt - rb != 0) begin errors++; $display("FAIL zero_pix_ready got %0d cycles want 0", pix_rdy_cnt - rb); end
        checks++; if (pe_q.size() - eb != 0) begin errors++; $display("FAIL zero_pe_count got %0d want 0", pe_q.size() - eb); end
        checks++; if (param_q.size() - pb != 4) begin errors++; $display("FAIL zero_param_count got %0d want 4", param_q.size() - pb); end
        if (param_q.size() - pb == 4 && done_cyc.size() > db) begin
            checks++;
            if (done_cyc[db] != param_cyc[pb+3] + PIPE_LAT) begin
                errors++; $display("FAIL zero_done_time got %0d want %0d", done_cyc[db], param_cyc[pb+3] + PIPE_LAT);
            end
        end
    endtask

    task automatic test_abort();
        gen_frame(10);
        drive_frame(10, 0, 4, -1, 0);
        checks++; if (abort_busy !== 1'b0) begin errors++; $display("FAIL abort_feed_busy got %b want 0", abort_busy); end
        checks++; if (abort_ovld !== 1'b0) begin errors++; $display("FAIL abort_feed_valids got %b want 0", abort_ovld); end
        checks++; if (pe_q.size() - eb != 4) begin errors++; $display("FAIL abort_feed_pe_count got %0d want 4", pe_q.size() - eb); end
        checks++; if (done_cyc.size() - db != 0) begin errors++; $display("FAIL abort_feed_done got %0d want 0", done_cyc.size() - db); end
        gen_frame(10);
        drive_frame(10, 0, -1, -1, 0);
        checks++; if (pe_q.size() - eb != 10) begin errors++; $display("FAIL abort_next_pe_count got %0d want 10", pe_q.size() - eb); end
        for (int i = 0; i < 10 && eb + i < pe_q.size(); i++) begin
            checks++;
            if (pe_q[eb+i] !== exp_pix[i]) begin errors++; $display("FAIL abort_next_pe[%0d] got %h want %h", i, pe_q[eb+i], exp_pix[i]); end
        end
        checks++; if (done_cyc.size() - db != 1) begin errors++; $display("FAIL abort_next_done got %0d want 1", done_cyc.size() - db); end
        // abort mid-word in PARAM must not leave stale bytes in the packer
        gen_frame(3);
        drive_frame(3, 0, -1, 4, 0);
        checks++; if (abort_busy !== 1'b0) begin errors++; $display("FAIL abort_param_busy got %b want 0", abort_busy); end
        gen_frame(3);
        drive_frame(3, 0, -1, -1, 0);
        checks++; if (param_q.size() - pb != 4) begin errors++; $display("FAIL abort_param_next_count got %0d want 4", param_q.size() - pb); end
        for (int i = 0; i < 4 && pb + i < param_q.size(); i++) begin
            checks++;
            if (param_q[pb+i] !== exp_param(i)) begin errors++; $display("FAIL abort_param_next[%0d] got %h want %h", i, param_q[pb+i], exp_param(i)); end
        end
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1; cfg_beats = 12'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b want 0", busy); end
        checks++; if (s_param_ready !== 1'b0) begin errors++; $display("FAIL start_abort_ready got %b want 0", s_param_ready); end
        repeat (2) @(negedge clk);
        gen_frame(3);
        drive_frame(3, 0, -1, -1, 1);
        checks++; if (pe_q.size() - eb != 3) begin errors++; $display("FAIL busy_start_pe_count got %0d want 3", pe_q.size() - eb); end
        checks++; if (done_cyc.size() - db != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", done_cyc.size() - db); end
    endtask

    task automatic test_param_bytes();
        gen_frame(1);
        drive_frame(1, 0, -1, -1, 0);
        checks++; if (param_xfer - xb != NB_EXP) begin errors++; $display("FAIL param_bytes_taken got %0d want %0d", param_xfer - xb, NB_EXP); end
        if (param_q.size() - pb >= 4) begin
            checks++;
            if (param_q[pb+3] !== exp_param(3)) begin errors++; $display("FAIL param_bias_word got %h want %h", param_q[pb+3], exp_param(3)); end
        end
    endtask

    task automatic test_reset_midframe();
        start = 1'b1; cfg_beats = 12'd3;
        @(negedge clk);
        start = 1'b0; s_param_valid = 1'b1; s_param_data = 8'h55;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s_param_valid = 1'b0;
        checks++; if ({busy, s_param_ready, o_param_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_flags got %b want 000", {busy, s_param_ready, o_param_valid});
        end
        rst = 1'b0;
        @(negedge clk);
        gen_frame(3);
        drive_frame(3, 0, -1, -1, 0);
        checks++; if (param_q.size() - pb != 4) begin errors++; $display("FAIL rst_mid_param_count got %0d want 4", param_q.size() - pb); end
        for (int i = 0; i < 4 && pb + i < param_q.size(); i++) begin
            checks++;
            if (param_q[pb+i] !== exp_param(i)) begin errors++; $display("FAIL rst_mid_param[%0d] got %h want %h", i, param_q[pb+i], exp_param(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_random();
        test_zero_beats();
        test_abort();
        test_start_abort();
        test_param_bytes();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter PIX_W, 24, bits per lane beat (3 pixels x 8 bits).
REQ-002 SHALL have parameter LANES, 7, pixel lanes driven into the conv datapath.
REQ-003 SHALL have parameter PIPE_LAT, 4, cycles waited after the last pixel beat before done.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to process one frame.
REQ-007 SHALL have port abort  in  1  one-cycle cancel request.
REQ-008 SHALL have port cfg_beats  in  12  pixel beats per frame, sampled on accepted start.
REQ-009 SHALL have ports s_param_data  in  8, s_param_valid  in  1, s_param_ready  out  1  form the parameter byte stream.
REQ-010 SHALL have ports s_pix_data  in  LANES*PIX_W, s_pix_valid  in  1, s_pix_ready  out  1  form the pixel stream.
REQ-011 SHALL have port o_param  out  26  [25:24] tag (0 = weight word, 1 = bias), [23:0] data.
REQ-012 SHALL have port o_param_valid  out  1  one-cycle strobe per o_param word.
REQ-013 SHALL have port o_pe_data  out  LANES*PIX_W  lane k in bits [24k-1:24(k-1)] feeds pe_k.
REQ-014 SHALL have ports o_pe_valid  out  1, busy  out  1, done  out  1.

Function
REQ-015 SHALL implement FSM IDLE, PARAM, FEED, FLUSH.
REQ-016 SHALL, in IDLE with start=1 and abort=0, latch cfg_beats, go to PARAM, and raise busy next cycle.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL hold s_param_ready=1 only in PARAM; a byte transfers when valid&ready.
REQ-019 SHALL pack 3 accepted bytes per weight word, first byte into [23:16], and emit o_param={2'd0,word} with o_param_valid=1 the cycle after the third byte.
REQ-020 SHALL emit exactly 3 weight words (9 weights) per frame, then the bias per REQ-032/REQ-033.
REQ-021 SHALL enter FEED the cycle after the bias word strobe.
REQ-022 SHALL hold s_pix_ready=1 only in FEED; on each accepted beat, register s_pix_data to o_pe_data and pulse o_pe_valid next cycle.
REQ-023 SHALL count accepted beats; the beat that reaches latched cfg_beats moves the FSM to FLUSH.
REQ-024 SHALL go PARAM->FLUSH directly, with no pixel beats, when latched cfg_beats=0.
REQ-025 SHALL wait PIPE_LAT cycles in FLUSH, then pulse done for one cycle, drop busy, and return to IDLE in the same cycle.
REQ-026 SHALL hold o_pe_data unchanged when no beat is accepted; stalls of either stream SHALL not drop or duplicate data.
REQ-027 SHALL, on abort in any state, go to IDLE next cycle: o_param_valid=0, o_pe_valid=0, partial byte and word counts cleared, no done pulse.
REQ-028 SHALL give abort priority over a simultaneous start.
REQ-029 SHALL keep the beat counter at 12 bits with no wrap: 4095 beats maximum.

Reset
REQ-030 SHALL on rst=1 set state IDLE and all counters 0, with outputs o_param=0, o_param_valid=0, o_pe_data=0, o_pe_valid=0, s_param_ready=0, s_pix_ready=0, busy=0, done=0.
REQ-031 SHALL treat rst mid-frame as abort, with rst taking priority over all inputs.

Configuration
REQ-032 SHALL, with CONV_SCHED_BIAS_EN defined, accept a 10th byte in PARAM and emit o_param={2'd1,16'd0,byte}.
REQ-033 SHALL, without CONV_SCHED_BIAS_EN, consume only 9 bytes and emit o_param={2'd1,24'd0} the cycle after the third weight word.

Structure
REQ-034 SHALL place the FSM state encoding, tag constants (TAG_WEIGHT=0, TAG_BIAS=1) and default PIX_W/LANES in shared package conv_pkg.
REQ-035 SHALL place byte-to-word packing in one sub-module, param_packer (byte stream in, 24-bit word plus strobe out).

Verification
REQ-036 SHALL cover: start, cfg_beats=2, bytes 01..0A back-to-back (BIAS_EN) -> o_param 0x010203, 0x040506, 0x070809 (tag 0), then 0x00000A (tag 1); 2 o_pe_valid pulses; done exactly PIPE_LAT cycles after the last o_pe_valid.
REQ-037 SHALL cover: param and pixel valid toggled 1/0 each cycle -> identical o_param sequence and o_pe_data values to the unstalled run, with no duplicates.
REQ-038 SHALL cover: cfg_beats=0 -> s_pix_ready never asserted; done PIPE_LAT cycles after the bias strobe.
REQ-039 SHALL cover: abort after the 4th pixel beat of 10 -> IDLE next cycle, no done; a following start runs a full frame correctly.
REQ-040 SHALL cover: start and abort in the same cycle -> stays IDLE with busy=0; start while busy -> ignored, cfg_beats unchanged.
REQ-041 SHALL cover: without BIAS_EN, 9 bytes -> 4th word tag 1 with data 0; s_param_ready low after byte 9.
